// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: same-cycle arbitration,
// an operand register stage and a per-requester registered result stage.

module alu #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       alu_cntr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             o_flag
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic        [WIDTH-1:0] sum;
    logic        [WIDTH-1:0] diff;
    logic                    add_ov;
    logic                    sub_ov;
    logic                    lt;

    assign a_s    = $signed(a);
    assign b_s    = $signed(b);
    assign sum    = a + b;
    assign diff   = a - b;
    // Signed overflow: operand signs vs. result sign.
    assign add_ov = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ov = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    assign lt     = (a_s < b_s);

    always_comb begin
        result = '0;
        o_flag = 1'b0;
        case (alu_cntr)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD: begin
                result = sum;
                o_flag = add_ov;
            end
            OP_XOR: result = a ^ b;
            OP_SUB: begin
                result = diff;
                o_flag = sub_ov;
            end
            OP_SLT: begin
                result = {{(WIDTH-1){1'b0}}, lt};
                o_flag = lt;
            end
            OP_NOR: result = ~(a | b);
            default: begin
                result = '0;
                o_flag = 1'b0;
            end
        endcase
    end

    assign z = (result == '0);

endmodule

module alu_arbiter #(
    parameter int WIDTH      = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_cntr,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             resp0_valid,
    output logic [WIDTH-1:0] resp0_result,
    output logic             resp0_z,
    output logic             resp0_ov,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_cntr,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp1_valid,
    output logic [WIDTH-1:0] resp1_result,
    output logic             resp1_z,
    output logic             resp1_ov,
    output logic             busy
);

    localparam logic PRIO0 = (FIXED_PRIO != 0);

    logic             last_grant;
    logic             grant0;
    logic             grant1;

    logic             vld_p1;
    logic             owner_p1;
    logic [3:0]       cntr_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;

    logic [WIDTH-1:0] alu_result;
    logic             alu_z;
    logic             alu_ov;

    // Requester 0 yields a conflict only under round-robin when it won last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            grant0 = req0_valid && (!req1_valid || PRIO0 || last_grant);
            grant1 = req1_valid && !grant0;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

    // Stage p1: operand register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            owner_p1 <= 1'b0;
        end else begin
            vld_p1   <= grant0 | grant1;
            owner_p1 <= grant1;
        end
    end

    always_ff @(posedge clk) begin
        if (grant0) begin
            cntr_p1 <= req0_cntr;
            a_p1    <= req0_a;
            b_p1    <= req0_b;
        end else if (grant1) begin
            cntr_p1 <= req1_cntr;
            a_p1    <= req1_a;
            b_p1    <= req1_b;
        end
    end

    alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .alu_cntr(cntr_p1),
        .a       (a_p1),
        .b       (b_p1),
        .result  (alu_result),
        .z       (alu_z),
        .o_flag  (alu_ov)
    );

    // Stage p2: per-requester result registers; data holds when not owner
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp0_valid  <= 1'b0;
            resp0_result <= '0;
            resp0_z      <= 1'b0;
            resp0_ov     <= 1'b0;
        end else begin
            resp0_valid <= vld_p1 && !owner_p1;
            if (vld_p1 && !owner_p1) begin
                resp0_result <= alu_result;
                resp0_z      <= alu_z;
                resp0_ov     <= alu_ov;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp1_valid  <= 1'b0;
            resp1_result <= '0;
            resp1_z      <= 1'b0;
            resp1_ov     <= 1'b0;
        end else begin
            resp1_valid <= vld_p1 && owner_p1;
            if (vld_p1 && owner_p1) begin
                resp1_result <= alu_result;
                resp1_z      <= alu_z;
                resp1_ov     <= alu_ov;
            end
        end
    end

    assign busy = vld_p1 | resp0_valid | resp1_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table-driven single operations plus
// contention, fairness, streaming and mid-operation reset sequences.

module tb_alu_arbiter;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_XOR = 4'b0011;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_NOR = 4'b1100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_cntr, req1_cntr;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;

    logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [31:0] resp0_result, resp1_result;
    logic        resp0_z, resp0_ov, resp1_z, resp1_ov, busy;

    logic        fp_req0_ready, fp_req1_ready, fp_resp0_valid, fp_resp1_valid;
    logic [31:0] fp_resp0_result, fp_resp1_result;
    logic        fp_resp0_z, fp_resp0_ov, fp_resp1_z, fp_resp1_ov, fp_busy;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [3:0]  cntr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ov;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cntr(req0_cntr),
        .req0_a(req0_a), .req0_b(req0_b),
        .resp0_valid(resp0_valid), .resp0_result(resp0_result),
        .resp0_z(resp0_z), .resp0_ov(resp0_ov),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cntr(req1_cntr),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp1_valid(resp1_valid), .resp1_result(resp1_result),
        .resp1_z(resp1_z), .resp1_ov(resp1_ov),
        .busy(busy)
    );

    alu_arbiter #(.WIDTH(32), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_cntr(req0_cntr),
        .req0_a(req0_a), .req0_b(req0_b),
        .resp0_valid(fp_resp0_valid), .resp0_result(fp_resp0_result),
        .resp0_z(fp_resp0_z), .resp0_ov(fp_resp0_ov),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_cntr(req1_cntr),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp1_valid(fp_resp1_valid), .resp1_result(fp_resp1_result),
        .resp1_z(fp_resp1_z), .resp1_ov(fp_resp1_ov),
        .busy(fp_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_cntr = C_AND; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_cntr = C_AND; req1_a = '0; req1_b = '0;
    endtask

    task automatic do_reset();
        next_cycle();
        rst_n = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        next_cycle();
        req0_valid = 1'b1;
        req0_cntr  = vecs[idx].cntr;
        req0_a     = vecs[idx].a;
        req0_b     = vecs[idx].b;
        @(negedge clk);
        chk({tag, " ready0"}, req0_ready, 1);
        next_cycle();
        req0_valid = 1'b0;
        req0_a     = 32'hDEAD_BEEF;
        @(negedge clk);
        chk({tag, " busy T+1"}, busy, 1);
        next_cycle();
        @(negedge clk);
        chk({tag, " resp0_valid"}, resp0_valid, 1);
        chk({tag, " resp0_result"}, resp0_result, vecs[idx].res);
        chk({tag, " resp0_z"}, resp0_z, vecs[idx].z);
        chk({tag, " resp0_ov"}, resp0_ov, vecs[idx].ov);
        chk({tag, " resp1_valid"}, resp1_valid, 0);
    endtask

    initial begin
        int     cnt0, cnt1, fp_cnt0, fp_cnt1, fp_rdy1;
        logic [31:0] exp0[$];
        logic [31:0] exp1[$];

        vecs[0]  = '{C_ADD, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
        vecs[1]  = '{C_SUB, 32'd3,          32'd3,          32'd0,          1'b1, 1'b0};
        vecs[2]  = '{C_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b1};
        vecs[3]  = '{C_SLT, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'd0,          1'b1, 1'b0};
        vecs[4]  = '{C_ADD, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b1};
        vecs[5]  = '{C_SUB, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b1};
        vecs[6]  = '{C_AND, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0, 1'b0};
        vecs[7]  = '{C_OR,  32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1'b0, 1'b0};
        vecs[8]  = '{C_NOR, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[9]  = '{C_XOR, 32'hA5A5_A5A5,  32'hA5A5_A5A5,  32'd0,          1'b1, 1'b0};
        vecs[10] = '{C_SLT, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0};

        rst_n = 1'b0;
        idle_inputs();

        // Reset with requests pending: nothing may be granted.
        next_cycle();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst ready0", req0_ready, 0);
        chk("rst ready1", req1_ready, 0);
        chk("rst resp0_valid", resp0_valid, 0);
        chk("rst resp1_valid", resp1_valid, 0);
        chk("rst resp0_result", resp0_result, 0);
        chk("rst resp1_result", resp1_result, 0);
        chk("rst flags", {resp0_z, resp0_ov, resp1_z, resp1_ov}, 0);
        chk("rst busy", busy, 0);
        next_cycle();
        rst_n = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk("idle busy", busy, 0);

        for (int i = 0; i < 11; i++) run_vec(i);

        // Contention right after reset: requester 0 wins first.
        do_reset();
        req0_valid = 1'b1; req0_cntr = C_SUB; req0_a = 32'd3; req0_b = 32'd3;
        req1_valid = 1'b1; req1_cntr = C_ADD; req1_a = 32'd1; req1_b = 32'd2;
        @(negedge clk);
        chk("cont T ready0", req0_ready, 1);
        chk("cont T ready1", req1_ready, 0);
        next_cycle();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("cont T+1 ready1", req1_ready, 1);
        next_cycle();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("cont T+2 resp0_valid", resp0_valid, 1);
        chk("cont T+2 resp0_result", resp0_result, 0);
        chk("cont T+2 resp0_z", resp0_z, 1);
        chk("cont T+2 resp1_valid", resp1_valid, 0);
        next_cycle();
        @(negedge clk);
        chk("cont T+3 resp1_valid", resp1_valid, 1);
        chk("cont T+3 resp1_result", resp1_result, 3);
        chk("cont T+3 resp0_valid", resp0_valid, 0);
        chk("cont T+3 resp0 hold", resp0_result, 0);

        // Fairness: both requesters valid for 8 cycles.
        cnt0 = 0; cnt1 = 0; fp_cnt0 = 0; fp_cnt1 = 0; fp_rdy1 = 0;
        for (int cyc = 0; cyc < 11; cyc++) begin
            next_cycle();
            if (cyc < 8) begin
                req0_valid = 1'b1; req0_cntr = C_ADD; req0_a = 32'd100 + cyc; req0_b = 32'd0;
                req1_valid = 1'b1; req1_cntr = C_ADD; req1_a = 32'd200 + cyc; req1_b = 32'd0;
            end else begin
                idle_inputs();
            end
            @(negedge clk);
            if (cyc < 8) begin
                chk($sformatf("rr ready0 c%0d", cyc), req0_ready, ((cyc % 2) == 0));
                chk($sformatf("rr ready1 c%0d", cyc), req1_ready, ((cyc % 2) == 1));
                chk($sformatf("fp ready0 c%0d", cyc), fp_req0_ready, 1);
                if ((cyc % 2) == 0) exp0.push_back(32'd100 + cyc);
                else                exp1.push_back(32'd200 + cyc);
            end
            if (fp_req1_ready) fp_rdy1++;
            if (resp0_valid) begin
                cnt0++;
                chk("rr resp0 pending", (exp0.size() > 0), 1);
                if (exp0.size() > 0) chk($sformatf("rr resp0 c%0d", cyc), resp0_result, exp0.pop_front());
            end
            if (resp1_valid) begin
                cnt1++;
                chk("rr resp1 pending", (exp1.size() > 0), 1);
                if (exp1.size() > 0) chk($sformatf("rr resp1 c%0d", cyc), resp1_result, exp1.pop_front());
            end
            if (fp_resp0_valid) fp_cnt0++;
            if (fp_resp1_valid) fp_cnt1++;
        end
        chk("rr resp0 count", cnt0, 4);
        chk("rr resp1 count", cnt1, 4);
        chk("fp resp0 count", fp_cnt0, 8);
        chk("fp resp1 count", fp_cnt1, 0);
        chk("fp ready1 count", fp_rdy1, 0);

        // Streaming: requester 1 alone for 5 consecutive cycles.
        for (int cyc = 0; cyc < 8; cyc++) begin
            next_cycle();
            if (cyc < 5) begin
                req1_valid = 1'b1; req1_cntr = C_ADD; req1_a = cyc; req1_b = 32'd1;
            end else begin
                req1_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc < 5) chk($sformatf("stream ready1 c%0d", cyc), req1_ready, 1);
            if (cyc >= 2 && cyc < 7) begin
                chk($sformatf("stream resp1_valid c%0d", cyc), resp1_valid, 1);
                chk($sformatf("stream resp1_result c%0d", cyc), resp1_result, cyc - 1);
            end
            if (cyc == 7) chk("stream resp1_valid end", resp1_valid, 0);
        end

        // Reset dropped while an operation is in the operand stage.
        next_cycle();
        req0_valid = 1'b1; req0_cntr = C_ADD; req0_a = 32'd5; req0_b = 32'd7;
        @(negedge clk);
        chk("midrst T ready0", req0_ready, 1);
        next_cycle();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        @(negedge clk);
        chk("midrst T+1 ready1", req1_ready, 0);
        next_cycle();
        rst_n = 1'b1;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("midrst T+2 resp0_valid", resp0_valid, 0);
        chk("midrst T+2 resp0_result", resp0_result, 0);
        chk("midrst T+2 resp1_result", resp1_result, 0);
        chk("midrst T+2 busy", busy, 0);
        next_cycle();
        req0_valid = 1'b1; req0_cntr = C_ADD; req0_a = 32'd2; req0_b = 32'd2;
        @(negedge clk);
        chk("postrst ready0", req0_ready, 1);
        next_cycle();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("postrst T+1 resp0_valid", resp0_valid, 0);
        next_cycle();
        @(negedge clk);
        chk("postrst resp0_valid", resp0_valid, 1);
        chk("postrst resp0_result", resp0_result, 4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
